// File: rtl/chu_vga_multi_sprite_core_pkg.sv
// Shared definitions for the multi-sprite overlay core: register offsets,
// the per-sprite control word layout, the global register select and the
// default frame-tick line.
package vga_sprite_pkg;

    localparam int   COORD_W       = 11;
    localparam int   ADDR_W        = 14;
    localparam int   VDISP_DEFAULT = 480;

    // Sprite field value that addresses the global register bank.
    localparam logic [2:0] GLOBAL_SEL = 3'd7;
    localparam logic [2:0] REG_BYPASS = 3'd0;

    typedef enum logic [2:0] {
        REG_X0     = 3'd0,
        REG_Y0     = 3'd1,
        REG_CTRL   = 3'd2,
        REG_PERIOD = 3'd3,
        REG_PAL1   = 3'd4,
        REG_PAL2   = 3'd5,
        REG_PAL3   = 3'd6,
        REG_NONE   = 3'd7
    } reg_sel_e;

    // ctrl[0] enable, [1] hflip, [2] animate, [4:3] static frame
    localparam int CTRL_EN     = 0;
    localparam int CTRL_HFLIP  = 1;
    localparam int CTRL_ANIM   = 2;
    localparam int CTRL_FRM_LO = 3;

    typedef struct packed {
        logic [1:0] frame;
        logic       animate;
        logic       hflip;
        logic       enable;
    } sprite_ctrl_t;

endpackage

// File: rtl/chu_vga_multi_sprite_core_if.sv
// Video-slot bus: chip select, write strobe, word address and write data.
// master drives the bus (host / testbench), slave is the sprite core.
interface chu_vga_multi_sprite_core_if;
    logic        cs;
    logic        write;
    logic [13:0] addr;
    logic [31:0] wr_data;

    modport master (output cs, write, addr, wr_data);
    modport slave  (input  cs, write, addr, wr_data);
endinterface

// File: rtl/chu_vga_multi_sprite_core_sprite_unit.sv
// One sprite: pending/active position and control, animation counter,
// hit/address generation, private bitmap RAM and palette.
// Ports:
//   clk, reset      clock, async active-high reset
//   tick            frame tick (start of vertical blank)
//   x, y            current pixel coordinates
//   reg_we/reg_sel  register write strobe and offset for this sprite
//   wr_data         bus write data
//   ram_we/ram_addr bitmap write strobe and local {frame,row,col} address
//   opaque, color   stage-2 result: sprite covers the pixel, and its colour
module sprite_unit
    import vga_sprite_pkg::*;
#(
    parameter int CD     = 12,
    parameter int SW     = 16,
    parameter int SH     = 16,
    parameter int FRAMES = 4,
    parameter int PW     = 2,
    localparam int CB    = $clog2(SW),
    localparam int RB    = $clog2(SH),
    localparam int FB    = $clog2(FRAMES),
    localparam int LB    = FB + RB + CB
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tick,
    input  logic [10:0]    x,
    input  logic [10:0]    y,
    input  logic           reg_we,
    input  reg_sel_e       reg_sel,
    input  logic [31:0]    wr_data,
    input  logic           ram_we,
    input  logic [LB-1:0]  ram_addr,
    output logic           opaque,
    output logic [CD-1:0]  color
);

    logic [10:0]   x0_p, y0_p, x0_a, y0_a;
    sprite_ctrl_t  ctrl_p, ctrl_a;
    logic [7:0]    period, cnt;
    logic [FB-1:0] frame;
    logic [CD-1:0] pal [0:(1<<PW)-1];
    logic [PW-1:0] mem [0:(1<<LB)-1];

    logic          hit_q;
    logic [PW-1:0] pix_q;

    logic [10:0]   dx, dy;
    logic          hit;
    logic [CB-1:0] col;
    logic [LB-1:0] rd_addr;

    // 11-bit wraparound subtraction lets a sprite clip off the left/top edge.
    assign dx  = x - x0_a;
    assign dy  = y - y0_a;
    assign hit = ctrl_a.enable && (dx < 11'(SW)) && (dy < 11'(SH));
    // SW is a power of two, so SW-1-dx is the bitwise complement of dx.
    assign col     = ctrl_a.hflip ? ~dx[CB-1:0] : dx[CB-1:0];
    assign rd_addr = {frame, dy[RB-1:0], col};

    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= wr_data[PW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0_p   <= '0;
            y0_p   <= '0;
            x0_a   <= '0;
            y0_a   <= '0;
            ctrl_p <= '0;
            ctrl_a <= '0;
            period <= '0;
            cnt    <= '0;
            frame  <= '0;
            hit_q  <= 1'b0;
            pix_q  <= '0;
            for (int i = 0; i < (1<<PW); i++)
                pal[i] <= '0;
        end else begin
            // Animation follows the control word that becomes active on this
            // tick, so a newly written static frame shows from the next pixel.
            if (tick) begin
                x0_a   <= x0_p;
                y0_a   <= y0_p;
                ctrl_a <= ctrl_p;
                if (ctrl_p.animate) begin
                    if (cnt == period) begin
                        frame <= frame + FB'(1);
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + 8'd1;
                    end
                end else begin
                    cnt   <= '0;
                    frame <= FB'(ctrl_p.frame);
                end
            end
            if (reg_we) begin
                case (reg_sel)
                    REG_X0:     x0_p   <= wr_data[10:0];
                    REG_Y0:     y0_p   <= wr_data[10:0];
                    REG_CTRL:   ctrl_p <= sprite_ctrl_t'(wr_data[4:0]);
                    REG_PERIOD: period <= wr_data[7:0];
                    REG_PAL1:   pal[1] <= wr_data[CD-1:0];
                    REG_PAL2:   pal[2] <= wr_data[CD-1:0];
                    REG_PAL3:   pal[3] <= wr_data[CD-1:0];
                    default:    ;
                endcase
            end
            hit_q <= hit;
            pix_q <= mem[rd_addr];
        end
    end

    // pal[0] is never written and stays 0; index 0 is masked by opaque anyway.
    assign opaque = hit_q && (pix_q != '0);
    assign color  = pal[pix_q];

endmodule

// File: rtl/chu_vga_multi_sprite_core.sv
// Multi-sprite overlay for the video-slot chain. Decodes bus writes into
// per-sprite bitmap/register writes, detects the frame tick, delays the
// upstream pixel and composites sprites by fixed priority (sprite 0 on top).
// Ports:
//   clk, reset  clock, async active-high reset
//   x, y        current pixel coordinates
//   bus         video-slot bus (slave)
//   si_rgb      upstream pixel
//   so_rgb      composited pixel, 2 cycles after x/y/si_rgb
module chu_vga_multi_sprite_core
    import vga_sprite_pkg::*;
#(
    parameter int CD     = 12,
    parameter int NSPR   = 4,
    parameter int SW     = 16,
    parameter int SH     = 16,
    parameter int FRAMES = 4,
    parameter int PW     = 2,
    parameter int VDISP  = VDISP_DEFAULT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [10:0]                    x,
    input  logic [10:0]                    y,
    chu_vga_multi_sprite_core_if.slave     bus,
    input  logic [CD-1:0]                  si_rgb,
    output logic [CD-1:0]                  so_rgb
);

    localparam int LB = $clog2(FRAMES) + $clog2(SH) + $clog2(SW);

    logic          we, tick, bypass;
    logic [2:0]    ram_spr, reg_spr;
    logic [CD-1:0] si_d1, mix;
    logic          opaque [NSPR];
    logic [CD-1:0] color  [NSPR];

    assign we      = bus.cs & bus.write;
    assign tick    = (x == 11'd0) && (y == 11'(VDISP));
    assign ram_spr = bus.addr[LB +: 3];
    assign reg_spr = bus.addr[5:3];

    for (genvar s = 0; s < NSPR; s++) begin : g_spr
        sprite_unit #(
            .CD(CD), .SW(SW), .SH(SH), .FRAMES(FRAMES), .PW(PW)
        ) u_spr (
            .clk      (clk),
            .reset    (reset),
            .tick     (tick),
            .x        (x),
            .y        (y),
            .reg_we   (we & bus.addr[13] & (reg_spr == 3'(s))),
            .reg_sel  (reg_sel_e'(bus.addr[2:0])),
            .wr_data  (bus.wr_data),
            .ram_we   (we & ~bus.addr[13] & (ram_spr == 3'(s))),
            .ram_addr (bus.addr[LB-1:0]),
            .opaque   (opaque[s]),
            .color    (color[s])
        );
    end

    // Walk from the highest index down so the lowest opaque sprite wins.
    always_comb begin
        mix = si_d1;
        for (int i = NSPR - 1; i >= 0; i--) begin
            if (opaque[i])
                mix = color[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bypass <= 1'b0;
            si_d1  <= '0;
            so_rgb <= '0;
        end else begin
            if (we && bus.addr[13] && reg_spr == GLOBAL_SEL && bus.addr[2:0] == REG_BYPASS)
                bypass <= bus.wr_data[0];
            si_d1  <= si_rgb;
            so_rgb <= bypass ? si_d1 : mix;
        end
    end

endmodule

// File: tb/tb_chu_vga_multi_sprite_core.sv
module tb_chu_vga_multi_sprite_core;

    localparam int VDISP = 480;

    logic        clk;
    logic        reset;
    logic [10:0] x, y;
    logic [11:0] si_rgb, so_rgb;

    chu_vga_multi_sprite_core_if bus_if ();

    chu_vga_multi_sprite_core dut (
        .clk    (clk),
        .reset  (reset),
        .x      (x),
        .y      (y),
        .bus    (bus_if),
        .si_rgb (si_rgb),
        .so_rgb (so_rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: sprite state as plain arrays, bitmaps as 2-D images.
    logic [1:0]  bmp    [4][4][16][16];
    logic [10:0] px [4], py [4], ax [4], ay [4];
    logic [4:0]  pctrl [4], actrl [4];
    logic [7:0]  period [4], cnt [4];
    int          frm [4];
    logic [11:0] pal [4][4];
    bit          bypass_m;

    logic [11:0] prev_exp;
    bit          prev_valid;
    int          prev_x, prev_y;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            px[s] = 0; py[s] = 0; ax[s] = 0; ay[s] = 0;
            pctrl[s] = 0; actrl[s] = 0; period[s] = 0; cnt[s] = 0; frm[s] = 0;
            for (int i = 0; i < 4; i++) pal[s][i] = 0;
        end
        bypass_m = 0;
    endtask

    function automatic logic [11:0] model_pixel(input int cx, input int cy, input logic [11:0] csi);
        int dx, dy, c;
        logic [1:0] idx;
        if (bypass_m) return csi;
        for (int s = 0; s < 4; s++) begin
            if (actrl[s][0]) begin
                dx = (cx - int'(ax[s]) + 2048) % 2048;
                dy = (cy - int'(ay[s]) + 2048) % 2048;
                if (dx < 16 && dy < 16) begin
                    c   = actrl[s][1] ? 15 - dx : dx;
                    idx = bmp[s][frm[s]][dy][c];
                    if (idx != 0) return pal[s][idx];
                end
            end
        end
        return csi;
    endfunction

    task automatic model_edge(input bit tk, input bit wr, input logic [13:0] a, input logic [31:0] d);
        int s, r;
        if (tk) begin
            for (int i = 0; i < 4; i++) begin
                ax[i] = px[i]; ay[i] = py[i]; actrl[i] = pctrl[i];
                if (pctrl[i][2]) begin
                    if (cnt[i] == period[i]) begin
                        frm[i] = (frm[i] + 1) % 4;
                        cnt[i] = 0;
                    end else begin
                        cnt[i] = 8'((int'(cnt[i]) + 1) % 256);
                    end
                end else begin
                    cnt[i] = 0;
                    frm[i] = int'(pctrl[i][4:3]);
                end
            end
        end
        if (wr) begin
            if (!a[13]) begin
                s = int'(a[12:10]);
                if (s < 4) bmp[s][a[9:8]][a[7:4]][a[3:0]] = d[1:0];
            end else begin
                s = int'(a[5:3]);
                r = int'(a[2:0]);
                if (s == 7 && r == 0) bypass_m = d[0];
                else if (s < 4) begin
                    case (r)
                        0: px[s] = d[10:0];
                        1: py[s] = d[10:0];
                        2: pctrl[s] = d[4:0];
                        3: period[s] = d[7:0];
                        4, 5, 6: pal[s][r-3] = d[11:0];
                        default: ;
                    endcase
                end
            end
        end
    endtask

    // One clock: drive at negedge, advance the model at posedge, then check
    // the pixel presented one cycle earlier (2-cycle latency).
    task automatic cycle(input int cx, input int cy, input logic [11:0] csi,
                         input bit wr, input logic [13:0] a, input logic [31:0] d);
        logic [11:0] e;
        x = 11'(cx); y = 11'(cy); si_rgb = csi;
        bus_if.cs = wr; bus_if.write = wr; bus_if.addr = a; bus_if.wr_data = d;
        e = model_pixel(cx % 2048, cy % 2048, csi);
        @(posedge clk);
        model_edge((cx % 2048) == 0 && (cy % 2048) == VDISP, wr, a, d);
        #1;
        if (prev_valid && !wr)
            check_val($sformatf("pix x=%0d y=%0d", prev_x, prev_y), so_rgb, prev_exp);
        prev_exp = e; prev_valid = !wr; prev_x = cx % 2048; prev_y = cy % 2048;
        @(negedge clk);
    endtask

    task automatic wr_reg(input int s, input int r, input logic [31:0] d);
        cycle(1, 0, 12'($urandom), 1, {1'b1, 7'd0, 3'(s), 3'(r)}, d);
    endtask

    task automatic wr_ram(input int s, input int f, input int r, input int c, input int v);
        cycle(1, 0, 12'($urandom), 1, {1'b0, 3'(s), 2'(f), 4'(r), 4'(c)}, 32'(v));
    endtask

    task automatic fill_frame(input int s, input int f, input int v);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                wr_ram(s, f, r, c, v);
    endtask

    task automatic do_tick();
        cycle(0, VDISP, 12'($urandom), 0, '0, '0);
    endtask

    task automatic scan(input int x0, input int y0, input int w, input int h);
        for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++)
                cycle((x0 + i) % 2048, (y0 + j) % 2048, 12'($urandom), 0, '0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1 check_val("rst_so", so_rgb, 12'h000);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        prev_valid = 0;
    endtask

    initial begin
        int s, sx;
        reset = 1'b1;
        x = 0; y = 0; si_rgb = 0;
        bus_if.cs = 0; bus_if.write = 0; bus_if.addr = 0; bus_if.wr_data = 0;
        for (int a = 0; a < 4; a++)
            for (int f = 0; f < 4; f++)
                for (int r = 0; r < 16; r++)
                    for (int c = 0; c < 16; c++)
                        bmp[a][f][r][c] = 0;
        model_reset();
        prev_valid = 0;
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Post-reset pipeline refill with a constant upstream colour.
        cycle(1, 0, 12'h123, 0, '0, '0);
        check_val("rst_fill1", so_rgb, 12'h000);
        cycle(1, 0, 12'h123, 0, '0, '0);
        cycle(1, 0, 12'h123, 0, '0, '0);

        // Random bitmaps everywhere; nothing is enabled yet.
        for (int a = 0; a < 4; a++)
            for (int f = 0; f < 4; f++)
                for (int r = 0; r < 16; r++)
                    for (int c = 0; c < 16; c++)
                        wr_ram(a, f, r, c, $urandom_range(0, 3));
        scan(0, 0, 8, 2);

        // Sprite 0: solid red square at (100,50); invisible until the tick.
        fill_frame(0, 0, 1);
        wr_reg(0, 4, 32'hF00);
        wr_reg(0, 0, 100);
        wr_reg(0, 1, 50);
        wr_reg(0, 2, 1);
        scan(98, 50, 20, 2);
        do_tick();
        scan(96, 46, 24, 24);

        // Sprite 1 overlapping, green; sprite 0 wins, then a hole in sprite 0.
        fill_frame(1, 0, 1);
        wr_reg(1, 4, 32'h0F0);
        wr_reg(1, 0, 108);
        wr_reg(1, 1, 58);
        wr_reg(1, 2, 1);
        do_tick();
        scan(104, 56, 24, 12);
        wr_ram(0, 0, 10, 10, 0);
        scan(108, 59, 6, 3);

        // Sprite 2 animation: period 2, frames in distinct colours, frame 3 clear.
        for (int f = 0; f < 4; f++) fill_frame(2, f, (f + 1) % 4);
        wr_reg(2, 4, 32'h00F);
        wr_reg(2, 5, 32'hFF0);
        wr_reg(2, 6, 32'h0FF);
        wr_reg(2, 3, 2);
        wr_reg(2, 0, 300);
        wr_reg(2, 1, 100);
        wr_reg(2, 2, 5);
        for (int k = 0; k < 14; k++) begin
            do_tick();
            scan(300, 100, 2, 1);
        end

        // Sprite 3: only column 0 lit, horizontally flipped.
        fill_frame(3, 0, 0);
        for (int r = 0; r < 16; r++) wr_ram(3, 0, r, 0, 3);
        wr_reg(3, 6, 32'hABC);
        wr_reg(3, 0, 200);
        wr_reg(3, 1, 300);
        wr_reg(3, 2, 3);
        do_tick();
        scan(196, 300, 24, 2);
        wr_reg(3, 0, 2044);
        do_tick();
        scan(2040, 300, 28, 2);

        // x0 written on the tick cycle: the old pending value is applied.
        cycle(0, VDISP, 12'($urandom), 1, {1'b1, 7'd0, 3'd0, 3'd0}, 32'd400);
        scan(98, 50, 6, 2);
        scan(398, 50, 6, 2);
        do_tick();
        scan(98, 50, 6, 2);
        scan(398, 50, 6, 2);

        // Bypass passes the upstream stream straight through.
        wr_reg(7, 0, 1);
        scan(398, 50, 20, 2);
        wr_reg(7, 0, 0);
        scan(398, 50, 20, 2);

        // Random register/RAM traffic, ticks and scans near active sprites.
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 7))
                0, 1: wr_reg($urandom_range(0, 7), $urandom_range(0, 7), $urandom);
                2:    wr_reg($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 2047));
                3:    wr_reg($urandom_range(0, 3), 3, $urandom_range(0, 3));
                4:    do_tick();
                5:    wr_ram($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 15),
                             $urandom_range(0, 15), $urandom_range(0, 3));
                default: begin
                    s  = $urandom_range(0, 3);
                    sx = int'(ax[s]) + 2048 - 2 + $urandom_range(0, 12);
                    scan(sx, int'(ay[s]) + $urandom_range(0, 15), 6, 2);
                end
            endcase
        end

        // Reset with sprites active: everything returns to pass-through.
        wr_reg(0, 2, 1);
        do_tick();
        scan(int'(ax[0]), int'(ay[0]), 4, 1);
        do_reset();
        cycle(int'(ax[0]), int'(ay[0]), 12'h456, 0, '0, '0);
        check_val("rst_mid", so_rgb, 12'h000);
        scan(int'(ax[0]), int'(ay[0]), 8, 2);
        do_tick();
        scan(96, 46, 8, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
